// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 16-way bus arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_t;

  localparam int NUM_REQ                = 16;
  localparam int ID_W                   = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/grant_dec16.sv
// Binary index to one-hot decoder; output is all-zero when en is low.
module grant_dec16
  import arb_pkg::*;
(
  input  logic [ID_W-1:0]    id,
  input  logic               en,
  output logic [NUM_REQ-1:0] oneHot
);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gDec
    assign oneHot[gi] = en && (id == ID_W'(gi));
  end

endmodule

// File: rtl/bus_arbiter_16.sv
// 16-requester round-robin arbiter with one idle bubble after every release.
// Optional grant-length limit compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter_16
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               Done,
  output logic [NUM_REQ-1:0] Grant,
  output logic [ID_W-1:0]    GrantId,
  output logic               GrantValid,
  output logic               Timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
    $error("bus_arbiter_16: TIMEOUT_CYCLES out of range 2..65535");
  end

  arbState_t       stateReg;
  logic [ID_W-1:0] ptrReg;
  logic [ID_W-1:0] grantIdReg;
  logic            grantValidReg;

  logic [ID_W-1:0] pickId;
  logic            pickFound;
  logic [ID_W-1:0] cand;
  logic            releaseReq;
  logic            expire;

  // Rotating priority: first requester at or after ptrReg, wrapping 15 -> 0.
  always_comb begin
    pickId    = '0;
    pickFound = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptrReg + ID_W'(i);
      if (!pickFound && Req[cand]) begin
        pickId    = cand;
        pickFound = 1'b1;
      end
    end
  end

  assign releaseReq = Done || !Req[grantIdReg];

`ifdef ARB_TIMEOUT_EN
  logic [15:0] grantCnt;
  logic        timeoutReg;

  assign expire = (stateReg == GRANT) && (grantCnt == 16'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero in IDLE, so every grant starts counting from zero.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      grantCnt   <= '0;
      timeoutReg <= 1'b0;
    end else begin
      grantCnt   <= (stateReg == GRANT) ? grantCnt + 16'd1 : 16'd0;
      timeoutReg <= expire && !releaseReq;
    end
  end

  assign Timeout = timeoutReg;
`else
  assign expire  = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stateReg      <= IDLE;
      ptrReg        <= '0;
      grantIdReg    <= '0;
      grantValidReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (pickFound) begin
            stateReg      <= GRANT;
            grantIdReg    <= pickId;
            grantValidReg <= 1'b1;
          end
        end
        GRANT: begin
          if (releaseReq || expire) begin
            stateReg      <= IDLE;
            grantValidReg <= 1'b0;
            ptrReg        <= grantIdReg + 1'b1;
          end
        end
        default: begin
          stateReg      <= IDLE;
          grantValidReg <= 1'b0;
        end
      endcase
    end
  end

  assign GrantId    = grantIdReg;
  assign GrantValid = grantValidReg;

  grant_dec16 uDec (
    .id     (grantIdReg),
    .en     (grantValidReg),
    .oneHot (Grant)
  );

endmodule

// File: tb/tb_bus_arbiter_16.sv
// Directed self-checking bench for bus_arbiter_16 (timeout checks follow ARB_TIMEOUT_EN).
module tb_bus_arbiter_16;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic [15:0] Req = 16'h0000;
  logic        Done = 1'b0;
  logic [15:0] Grant;
  logic [3:0]  GrantId;
  logic        GrantValid;
  logic        Timeout;

  int checks = 0;
  int failures = 0;

  // Observed bundle: {Timeout, GrantValid, GrantId, Grant}
  logic [21:0] obs;
  assign obs = {Timeout, GrantValid, GrantId, Grant};

  always #5 Clock = ~Clock;

  bus_arbiter_16 #(.TIMEOUT_CYCLES(4)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Req        (Req),
    .Done       (Done),
    .Grant      (Grant),
    .GrantId    (GrantId),
    .GrantValid (GrantValid),
    .Timeout    (Timeout)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs, {1'b0, 1'b0, 4'd0, 16'h0000});
    end
    tick;
    tick;
    Reset_n = 1'b1;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", obs, {1'b0, 1'b0, 4'd0, 16'h0000});
    end
    $display("reset: obs=%h", obs);
  endtask

  task automatic test_single;
    Req = 16'h0010;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd4, 16'h0010}) begin
      failures++;
      $display("FAIL single_grant got=%h exp=%h", obs, {1'b0, 1'b1, 4'd4, 16'h0010});
    end
    $display("single: id=%0d grant=%h", GrantId, Grant);
  endtask

  task automatic test_wrap;
    Req = 16'h0011;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd4, 16'h0010}) begin
      failures++;
      $display("FAIL wrap_hold got=%h exp=%h", obs, {1'b0, 1'b1, 4'd4, 16'h0010});
    end
    Req = 16'h0001;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd4, 16'h0000}) begin
      failures++;
      $display("FAIL wrap_bubble got=%h exp=%h", obs, {1'b0, 1'b0, 4'd4, 16'h0000});
    end
    tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd0, 16'h0001}) begin
      failures++;
      $display("FAIL wrap_grant0 got=%h exp=%h", obs, {1'b0, 1'b1, 4'd0, 16'h0001});
    end
    $display("wrap: id=%0d grant=%h", GrantId, Grant);
    Req = 16'h0000;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd0, 16'h0000}) begin
      failures++;
      $display("FAIL wrap_release got=%h exp=%h", obs, {1'b0, 1'b0, 4'd0, 16'h0000});
    end
  endtask

  // Pointer is 1 here; holder 3 must keep the bus while Req[9] toggles.
  task automatic test_hold;
    Req = 16'h0008;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd3, 16'h0008}) begin
      failures++;
      $display("FAIL hold_grant got=%h exp=%h", obs, {1'b0, 1'b1, 4'd3, 16'h0008});
    end
    for (int i = 0; i < 6; i++) begin
      Req = (i % 2 == 0) ? 16'h0208 : 16'h0008;
      tick;
      checks++;
      if (obs !== {1'b0, 1'b1, 4'd3, 16'h0008}) begin
        failures++;
        $display("FAIL hold_toggle%0d got=%h exp=%h", i, obs, {1'b0, 1'b1, 4'd3, 16'h0008});
      end
    end
    Req = 16'h0208;
    Done = 1'b1;
    tick;
    Done = 1'b0;
    Req = 16'h0000;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd3, 16'h0000}) begin
      failures++;
      $display("FAIL hold_done got=%h exp=%h", obs, {1'b0, 1'b0, 4'd3, 16'h0000});
    end
    $display("hold: released id=3 obs=%h", obs);
  endtask

  // Pointer is 4 here; Done while IDLE must not block or release anything.
  task automatic test_done_in_idle;
    Done = 1'b1;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd3, 16'h0000}) begin
      failures++;
      $display("FAIL idle_done_noreq got=%h exp=%h", obs, {1'b0, 1'b0, 4'd3, 16'h0000});
    end
    Req = 16'h0020;
    tick;
    Done = 1'b0;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd5, 16'h0020}) begin
      failures++;
      $display("FAIL idle_done_grant got=%h exp=%h", obs, {1'b0, 1'b1, 4'd5, 16'h0020});
    end
    tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd5, 16'h0020}) begin
      failures++;
      $display("FAIL idle_done_keep got=%h exp=%h", obs, {1'b0, 1'b1, 4'd5, 16'h0020});
    end
    Req = 16'h0000;
    tick;
    $display("done_in_idle: id=%0d obs=%h", GrantId, obs);
  endtask

  // Pointer is 6 here; reset mid-grant must clear everything without a clock edge.
  task automatic test_reset_mid_grant;
    Req = 16'h0040;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd6, 16'h0040}) begin
      failures++;
      $display("FAIL midrst_grant got=%h exp=%h", obs, {1'b0, 1'b1, 4'd6, 16'h0040});
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd0, 16'h0000}) begin
      failures++;
      $display("FAIL midrst_drop got=%h exp=%h", obs, {1'b0, 1'b0, 4'd0, 16'h0000});
    end
    tick;
    Reset_n = 1'b1;
    Req = 16'h0000;
    tick;
    $display("reset_mid_grant: obs=%h", obs);
  endtask

  // Pointer is back to 0 after reset, so the sequence must start at 0.
  task automatic test_round_robin;
    logic [15:0] expG;
    logic [3:0]  expId;
    Req = 16'hFFFF;
    tick;
    for (int k = 0; k < 17; k++) begin
      expId = 4'(k % 16);
      expG = 16'h0001 << (k % 16);
      checks++;
      if (obs !== {1'b0, 1'b1, expId, expG}) begin
        failures++;
        $display("FAIL rr_grant%0d got=%h exp=%h", k, obs, {1'b0, 1'b1, expId, expG});
      end
      $display("rr: grant #%0d id=%0d grant=%h", k, GrantId, Grant);
      Done = 1'b1;
      tick;
      Done = 1'b0;
      checks++;
      if (obs !== {1'b0, 1'b0, expId, 16'h0000}) begin
        failures++;
        $display("FAIL rr_bubble%0d got=%h exp=%h", k, obs, {1'b0, 1'b0, expId, 16'h0000});
      end
      tick;
    end
    Req = 16'h0000;
    tick;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    Reset_n = 1'b0;
    tick;
    Reset_n = 1'b1;
    Req = 16'h0003;
    tick;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== {1'b0, 1'b1, 4'd0, 16'h0001}) begin
        failures++;
        $display("FAIL to_hold%0d got=%h exp=%h", c, obs, {1'b0, 1'b1, 4'd0, 16'h0001});
      end
      tick;
    end
    checks++;
    if (obs !== {1'b1, 1'b0, 4'd0, 16'h0000}) begin
      failures++;
      $display("FAIL to_pulse got=%h exp=%h", obs, {1'b1, 1'b0, 4'd0, 16'h0000});
    end
    $display("timeout: pulse obs=%h", obs);
    tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 4'd1, 16'h0002}) begin
      failures++;
      $display("FAIL to_next got=%h exp=%h", obs, {1'b0, 1'b1, 4'd1, 16'h0002});
    end
    tick;
    tick;
    tick;
    Done = 1'b1;
    tick;
    Done = 1'b0;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd1, 16'h0000}) begin
      failures++;
      $display("FAIL to_done_race got=%h exp=%h", obs, {1'b0, 1'b0, 4'd1, 16'h0000});
    end
    $display("timeout: done+expiry obs=%h", obs);
    Req = 16'h0000;
    tick;
  endtask
`else
  task automatic test_no_timeout;
    Reset_n = 1'b0;
    tick;
    Reset_n = 1'b1;
    Req = 16'h0003;
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++;
      if (obs !== {1'b0, 1'b1, 4'd0, 16'h0001}) begin
        failures++;
        $display("FAIL nto_hold%0d got=%h exp=%h", c, obs, {1'b0, 1'b1, 4'd0, 16'h0001});
      end
    end
    $display("no_timeout: grant held 10 cycles obs=%h", obs);
    Req = 16'h0000;
    tick;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd0, 16'h0000}) begin
      failures++;
      $display("FAIL nto_release got=%h exp=%h", obs, {1'b0, 1'b0, 4'd0, 16'h0000});
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_hold;
    test_done_in_idle;
    test_reset_mid_grant;
    test_round_robin;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
